// File: rtl/video_composite_timing_ms.sv
// NTSC/PAL composite sync and timing generator with half-line vertical counting,
// interlaced or progressive scan, and mode changes applied only at frame boundaries.
module video_composite_timing_ms #(
  parameter int unsigned H_SYNC            = 118,
  parameter int unsigned H_BACK_PORCH      = 152,
  parameter int unsigned H_ACTIVE          = 1280,
  parameter int unsigned H_TOTAL_NTSC      = 1588,
  parameter int unsigned H_TOTAL_PAL       = 1600,
  parameter int unsigned H_VSYNC_PULSE_LEN = 678,
  parameter int unsigned H_EQ_PULSE_LEN    = 58,
  parameter int unsigned H_BURST_START     = 132,
  parameter int unsigned H_BURST_END       = 196,
  parameter int unsigned V_ACT_START_NTSC  = 42,
  parameter int unsigned V_ACT_START_PAL   = 46,
  parameter int unsigned V_ACT_LINES_NTSC  = 240,
  parameter int unsigned V_ACT_LINES_PAL   = 288
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pal_req,
  input  logic        prog_req,
  output logic        pal,
  output logic        prog,
  output logic [10:0] hcnt,
  output logic [9:0]  vcnt,
  output logic        current_field,
  output logic        next_frame,
  output logic        next_line,
  output logic        next_pixel,
  output logic        vblank_pulse,
  output logic        active,
  output logic        color_burst,
  output logic        burst_phase,
  output logic        sync_n
);

  localparam logic [10:0] HT_N_LAST   = 11'(H_TOTAL_NTSC - 1);
  localparam logic [10:0] HT_P_LAST   = 11'(H_TOTAL_PAL - 1);
  localparam logic [10:0] HH_N        = 11'(H_TOTAL_NTSC / 2);
  localparam logic [10:0] HH_P        = 11'(H_TOTAL_PAL / 2);
  localparam logic [10:0] PIX_START   = 11'(H_SYNC + H_BACK_PORCH);
  localparam logic [10:0] PIX_END     = 11'(H_SYNC + H_BACK_PORCH + H_ACTIVE);
  localparam logic [10:0] LINE_STROBE = 11'(H_SYNC + H_BACK_PORCH - 1);
  localparam logic [10:0] SYNC_LEN    = 11'(H_SYNC);
  localparam logic [10:0] BROAD_LEN   = 11'(H_VSYNC_PULSE_LEN);
  localparam logic [10:0] EQ_LEN      = 11'(H_EQ_PULSE_LEN);
  localparam logic [10:0] BURST_S     = 11'(H_BURST_START);
  localparam logic [10:0] BURST_E     = 11'(H_BURST_END);
  localparam logic [9:0]  VAS_N       = 10'(V_ACT_START_NTSC);
  localparam logic [9:0]  VAS_P       = 10'(V_ACT_START_PAL);
  localparam logic [9:0]  VAL2_N      = 10'(2 * V_ACT_LINES_NTSC);
  localparam logic [9:0]  VAL2_P      = 10'(2 * V_ACT_LINES_PAL);

  typedef enum logic [1:0] {REG_EQ, REG_VSYNC, REG_NORMAL} vregion_e;

  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic        field_q, field_d;
  logic        cur_field_q, cur_field_d;
  logic        pal_q, pal_d;
  logic        prog_q, prog_d;
  logic        bp_q, bp_d;

  logic [10:0] ht_last_s, hh_s, hpos_s;
  logic [9:0]  fl_last_s, e_s, vs_s, vend_s;
  logic        h_wrap_s, half_end_s, v_wrap_s, frame_end_s;
  logic        v_active_s, line_strobe_s, frame_strobe_s;
  vregion_e    region_s;

  // Geometry of the frame currently being generated.
  always_comb begin
    ht_last_s = pal_q ? HT_P_LAST : HT_N_LAST;
    hh_s      = pal_q ? HH_P : HH_N;
    if (pal_q) begin
      fl_last_s = prog_q ? 10'd625 : 10'd624;
    end else begin
      fl_last_s = prog_q ? 10'd525 : 10'd524;
    end
    e_s    = pal_q ? 10'd5 : 10'd6;
    vs_s   = (pal_q ? VAS_P : VAS_N) + {9'd0, ~prog_q & field_q};
    vend_s = vs_s + (pal_q ? VAL2_P : VAL2_N);
  end

  assign h_wrap_s       = (hcnt_q == ht_last_s);
  assign half_end_s     = h_wrap_s | (hcnt_q == (hh_s - 11'd1));
  assign v_wrap_s       = half_end_s & (vcnt_q == fl_last_s);
  assign frame_end_s    = v_wrap_s & (prog_q | field_q);
  assign hpos_s         = (hcnt_q >= hh_s) ? (hcnt_q - hh_s) : hcnt_q;
  assign v_active_s     = (vcnt_q >= vs_s) & (vcnt_q < vend_s);
  assign line_strobe_s  = (hcnt_q == LINE_STROBE);
  assign frame_strobe_s = line_strobe_s & (vcnt_q == vs_s);

  // Vertical region classification on the half-line index.
  always_comb begin
    region_s = REG_NORMAL;
    if (vcnt_q < e_s) begin
      region_s = REG_EQ;
    end else if (vcnt_q < {e_s[8:0], 1'b0}) begin
      region_s = REG_VSYNC;
    end else if (vcnt_q < (e_s * 10'd3)) begin
      region_s = REG_EQ;
    end else begin
      region_s = REG_NORMAL;
    end
  end

  // Composite sync; broad and equalization pulses repeat every half-line.
  always_comb begin
    sync_n = 1'b0;
    case (region_s)
      REG_EQ:     sync_n = ~(hpos_s < EQ_LEN);
      REG_VSYNC:  sync_n = ~(hpos_s < BROAD_LEN);
      REG_NORMAL: sync_n = ~(hcnt_q < SYNC_LEN);
      default:    sync_n = 1'b0;
    endcase
  end

  // Next-state for counters, field, mode latch and PAL V-switch.
  always_comb begin
    hcnt_d      = h_wrap_s ? 11'd0 : (hcnt_q + 11'd1);
    vcnt_d      = vcnt_q;
    field_d     = field_q;
    pal_d       = pal_q;
    prog_d      = prog_q;
    cur_field_d = cur_field_q;
    bp_d        = 1'b0;
    if (half_end_s) begin
      if (v_wrap_s) begin
        vcnt_d  = 10'd0;
        field_d = prog_q ? 1'b0 : ~field_q;
      end else begin
        vcnt_d  = vcnt_q + 10'd1;
      end
    end else begin
      vcnt_d = vcnt_q;
    end
    if (frame_end_s) begin
      pal_d  = pal_req;
      prog_d = prog_req;
    end else begin
      pal_d  = pal_q;
      prog_d = prog_q;
    end
    if (frame_strobe_s) begin
      cur_field_d = field_q;
    end else begin
      cur_field_d = cur_field_q;
    end
    if (pal_q) begin
      bp_d = h_wrap_s ? ~bp_q : bp_q;
    end else begin
      bp_d = 1'b0;
    end
  end

  // State registers; reset restarts at frame start in NTSC interlaced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q      <= 11'd0;
      vcnt_q      <= 10'd0;
      field_q     <= 1'b0;
      cur_field_q <= 1'b0;
      pal_q       <= 1'b0;
      prog_q      <= 1'b0;
      bp_q        <= 1'b0;
    end else begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      field_q     <= field_d;
      cur_field_q <= cur_field_d;
      pal_q       <= pal_d;
      prog_q      <= prog_d;
      bp_q        <= bp_d;
    end
  end

  assign pal           = pal_q;
  assign prog          = prog_q;
  assign hcnt          = hcnt_q;
  assign vcnt          = vcnt_q;
  assign current_field = cur_field_q;
  assign next_frame    = frame_strobe_s;
  assign next_line     = line_strobe_s;
  assign next_pixel    = (hcnt_q >= PIX_START) & (hcnt_q < PIX_END);
  assign vblank_pulse  = v_wrap_s;
  assign active        = next_pixel & v_active_s;
  assign color_burst   = v_active_s & (hcnt_q >= BURST_S) & (hcnt_q < BURST_E);
  assign burst_phase   = bp_q;

endmodule

// File: doc/video_composite_timing_ms.md
# video_composite_timing_ms

Multi-standard composite/RGB sync and timing generator: NTSC (525 lines) or PAL (625 lines), each interlaced or 263/313-line progressive, selectable at run time. It sits between the line-buffer/palette path and the `video_modulator`. It supplies:

- the line-buffer strobes;
- the composite sync;
- burst and active gating;
- the per-line PAL burst phase.

Requested mode changes take effect only at a frame boundary, so the display never sees a torn frame.

## Interface
- H_SYNC, 118: hsync pulse length (clocks)
- H_BACK_PORCH, 152: clocks from end of sync to first active pixel
- H_ACTIVE, 1280: active clocks per line
- H_TOTAL_NTSC, 1588: NTSC line length (must be even)
- H_TOTAL_PAL, 1600: PAL line length (must be even)
- H_VSYNC_PULSE_LEN, 678: broad-pulse length per half-line
- H_EQ_PULSE_LEN, 58: equalization pulse length per half-line
- H_BURST_START, 132: first burst clock
- H_BURST_END, 196: first clock after burst
- V_ACT_START_NTSC, 42: first active half-line in field 0, NTSC
- V_ACT_START_PAL, 46: first active half-line in field 0, PAL
- V_ACT_LINES_NTSC, 240: active lines per field, NTSC
- V_ACT_LINES_PAL, 288: active lines per field, PAL

Ports:
- clk  in  1  video clock
- rst  in  1  reset, asynchronous, active-high
- pal_req  in  1  requested standard (0 NTSC, 1 PAL)
- prog_req  in  1  requested scan (0 interlaced, 1 progressive)
- pal  out  1  effective standard
- prog  out  1  effective scan
- hcnt  out  11  horizontal position
- vcnt  out  10  half-line index within the current field
- current_field  out  1  field of the frame being fetched
- next_frame  out  1  one-clock strobe at the start of each field's active area
- next_line  out  1  one-clock strobe, one clock before the first active pixel
- next_pixel  out  1  horizontal active window
- vblank_pulse  out  1  one-clock strobe on the last clock of each field
- active  out  1  horizontal and vertical active
- color_burst  out  1  burst gate
- burst_phase  out  1  PAL V-switch; always 0 in NTSC
- sync_n  out  1  composite sync, active-low

## Operation
**Derived values**
- HT = pal ? H_TOTAL_PAL : H_TOTAL_NTSC; HH = HT/2.
- FL (field length in half-lines) = (pal ? 625 : 525) + prog.
- E (equalization/vsync block length) = pal ? 5 : 6.
- VS = V_ACT_START of the effective standard + (~prog & field).

**Counters**
- hcnt wraps at HT-1.
- vcnt advances when hcnt is HH-1 or HT-1, and wraps at FL-1.
- At a field wrap, `field` toggles if interlaced and holds 0 if progressive.

**Vertical regions (on vcnt)**
- 0..E-1: equalization.
- E..2E-1: vsync.
- 2E..3E-1: equalization.
- Otherwise: normal lines.

**sync_n by region**
- vsync region: low when (hcnt mod HH) < H_VSYNC_PULSE_LEN.
- equalization region: low when (hcnt mod HH) < H_EQ_PULSE_LEN.
- normal lines: low when hcnt < H_SYNC.

**Windows and gates**
- v_active: vcnt in VS..VS+2·V_ACT_LINES-1.
- next_pixel: hcnt in [H_SYNC+H_BACK_PORCH, H_SYNC+H_BACK_PORCH+H_ACTIVE).
- active = next_pixel & v_active.
- color_burst = v_active & hcnt in [H_BURST_START, H_BURST_END).

**Strobes**
- next_line fires when hcnt == H_SYNC+H_BACK_PORCH-1, on every line.
- next_frame fires together with the next_line of the first line with vcnt == VS. current_field loads `field` on the same clock.
- vblank_pulse fires on the clock where the vcnt wrap occurs.

**burst_phase**
- Toggles at every hcnt == HT-1 while pal = 1.
- Forced to 0 while pal = 0.

**Mode latch**
- pal_req and prog_req are sampled into pal and prog only at the frame end: the vcnt wrap with field = 1 (interlaced) or any vcnt wrap (progressive).
- Requests changing mid-frame have no effect until that point; the last value before the boundary wins.

## Timing
**Reset values**
- hcnt = 0, vcnt = 0, field = 0, current_field = 0.
- pal = 0, prog = 0, burst_phase = 0.
- Strobe state cleared. sync_n = 0, since position 0 lies in the equalization region.

**Sequencing**
- All outputs are combinational decodes of registered state, valid in the same clock as the hcnt/vcnt values they describe.
- The first pixel is presented to the line buffer one clock after next_line.
- Reset asserted mid-frame returns everything to position 0 immediately. Release resumes from frame start in NTSC interlaced mode.

**Boundary conditions**
- At a mode-switch boundary, the new HT and FL apply from the first clock of the new frame. No partial line is emitted.
- If the hcnt and vcnt wraps coincide at HT-1 with the frame end, all wraps, the field update and the mode latch occur on the same edge.

## Test plan
- **NTSC interlaced reset run:** run 833,700 clocks (1050 × 794). Require:
  - vblank_pulse at clocks 416,849 and 833,699;
  - field 1 starts at hcnt = 794;
  - next_frame count = 2, current_field 0 then 1;
  - 480 active lines per frame.
- **PAL interlaced:** set pal_req = 1 and wait one frame boundary. Then require:
  - frame period = 1,000,000 clocks;
  - 5 broad pulses of 678 clocks each per field;
  - burst_phase alternating on consecutive lines;
  - 576 active lines per frame.
- **NTSC progressive:** prog_req = 1. Require:
  - field period 417,644 clocks;
  - current_field always 0;
  - vblank_pulse every 526 half-lines.
- **Mid-frame request:** toggle pal_req at vcnt = 300 of field 0. Require that pal changes only on the clock after the field-1 wrap, and that the preceding frame is a complete 833,700 clocks.
- **Reset mid-line:** assert rst at hcnt = 500, vcnt = 100. Require:
  - outputs at reset values within the same clock;
  - after release, sync_n equalization pulse of 58 clocks at hcnt 0.
- **Burst gating:** on vcnt = 10 (vsync) and on the first active line, require color_burst = 0 and 1 respectively. When 1, it must span exactly hcnt 132..195.
